// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
// Holds the occupancy state encodings and the flat field-slice helper.
package pipe_pkg;

    localparam logic [1:0] PIPE_ST_EMPTY = 2'd0;
    localparam logic [1:0] PIPE_ST_BUSY  = 2'd1;
    localparam logic [1:0] PIPE_ST_FULL  = 2'd2;

    // Bit offset of field idx inside a flat vector of width-bit fields.
    function automatic int unsigned field_offset(input int unsigned idx,
                                                 input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/pipe_field_bank.sv
// NUM_FIELDS x DATA_WIDTH storage bank with synchronous clear and load enable.
// Clear wins over load.
module pipe_field_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_FIELDS = 4
) (
    input  logic                           clk,
    input  logic                           i_clr,
    input  logic                           i_load,
    input  logic [NUM_FIELDS*DATA_WIDTH-1:0] i_d,
    output logic [NUM_FIELDS*DATA_WIDTH-1:0] o_q
);

    // Register the whole bank; clear has priority over load.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            o_q <= '0;
        end else if (i_load) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Parametrised pipeline register with valid/ready handshake and a 2-entry
// skid buffer (registered o_ready, full throughput). Synchronous flush
// inserts an all-zero bubble.
// Optional debug readback of a main-bank field: define PIPE_SKID_REG_DEBUG_EN.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_FIELDS = 4,
    parameter int SEL_WIDTH  = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                             clk,
    input  logic                             i_rst,
    input  logic                             i_flush,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [NUM_FIELDS*DATA_WIDTH-1:0] i_fields,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [NUM_FIELDS*DATA_WIDTH-1:0] o_fields,
    output logic [1:0]                       o_count
`ifdef PIPE_SKID_REG_DEBUG_EN
    ,
    input  logic [SEL_WIDTH-1:0]             i_dbg_sel,
    output logic [DATA_WIDTH-1:0]            o_dbg_data
`endif
);

    localparam int FW = NUM_FIELDS * DATA_WIDTH;

    if (NUM_FIELDS < 1 || SEL_WIDTH < 1) begin : g_param_check
        $error("pipe_skid_reg: NUM_FIELDS and SEL_WIDTH must be at least 1");
    end

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          xfer_in;
    logic          xfer_out;
    logic          main_clr;
    logic          main_load;
    logic [FW-1:0] main_d;
    logic          skid_clr;
    logic          skid_load;
    logic [FW-1:0] skid_q;

    // Handshake outputs come straight from the state register.
    assign o_valid  = (state != PIPE_ST_EMPTY);
    assign o_ready  = (state != PIPE_ST_FULL);
    assign o_count  = state;
    assign xfer_in  = i_valid & o_ready;
    assign xfer_out = o_valid & i_ready;

    // Next state and bank controls. The main bank loads either fresh input
    // or the skid entry when draining from FULL; the bank that gives up its
    // entry is cleared so empty slots always read as zero.
    always_comb begin
        state_nxt = state;
        main_clr  = 1'b0;
        main_load = 1'b0;
        main_d    = i_fields;
        skid_clr  = 1'b0;
        skid_load = 1'b0;
        if (i_rst || i_flush) begin
            state_nxt = PIPE_ST_EMPTY;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            case (state)
                PIPE_ST_EMPTY: begin
                    if (xfer_in) begin
                        state_nxt = PIPE_ST_BUSY;
                        main_load = 1'b1;
                    end
                end
                PIPE_ST_BUSY: begin
                    if (xfer_in && xfer_out) begin
                        main_load = 1'b1;
                    end else if (xfer_in) begin
                        state_nxt = PIPE_ST_FULL;
                        skid_load = 1'b1;
                    end else if (xfer_out) begin
                        state_nxt = PIPE_ST_EMPTY;
                        main_clr  = 1'b1;
                    end
                end
                PIPE_ST_FULL: begin
                    if (xfer_out) begin
                        state_nxt = PIPE_ST_BUSY;
                        main_d    = skid_q;
                        main_load = 1'b1;
                        skid_clr  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = PIPE_ST_EMPTY;
                    main_clr  = 1'b1;
                    skid_clr  = 1'b1;
                end
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        state <= state_nxt;
    end

    pipe_field_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_FIELDS (NUM_FIELDS)
    ) u_main_bank (
        .clk    (clk),
        .i_clr  (main_clr),
        .i_load (main_load),
        .i_d    (main_d),
        .o_q    (o_fields)
    );

    pipe_field_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_FIELDS (NUM_FIELDS)
    ) u_skid_bank (
        .clk    (clk),
        .i_clr  (skid_clr),
        .i_load (skid_load),
        .i_d    (i_fields),
        .o_q    (skid_q)
    );

`ifdef PIPE_SKID_REG_DEBUG_EN
    // Debug readback of one main-bank field; out-of-range selects read zero.
    always_comb begin
        o_dbg_data = '0;
        for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
            if (int'(i_dbg_sel) == int'(k)) begin
                o_dbg_data = o_fields[field_offset(k, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end
`endif

endmodule
